// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit full adder, reused once per cycle, LSB first.
// A three-state FSM sequences IDLE -> ADD (WIDTH cycles) -> DONE (one cycle).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, co_q, co_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          c_d     = carry_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Result fills from the MSB end so after WIDTH shifts bit 0 lands at LSB.
        res_d = {fa_s, res_q[WIDTH-1:1]};
        c_d   = fa_co;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = co_q;
  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=2 sweep.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, co8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, co2, busy2, done2;
  logic [1:0] a2, b2, sum2;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
    .carry_in(cin8), .sum(sum8), .carry_out(co8), .busy(busy8), .done(done8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(a2), .op_b(b2),
    .carry_in(cin2), .sum(sum2), .carry_out(co2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 addition and observe 14 edges; optionally disturb inputs mid-ADD.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic disturb, output logic [7:0] s, output logic co,
                      output int nbusy, output int ndone, output int done_at,
                      output logic stable, output int olap);
    logic [7:0] s0;
    s0 = sum8;
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    nbusy = 0; ndone = 0; done_at = -1; stable = 1'b1; olap = 0;
    s = sum8; co = co8;
    for (int i = 0; i < 14; i++) begin
      if (busy8) begin
        nbusy++;
        if (sum8 !== s0) stable = 1'b0;
      end
      if (done8) begin
        ndone++;
        if (done_at < 0) done_at = i;
        s = sum8; co = co8;
      end
      if (busy8 && done8) olap++;
      if (disturb && i == 3) begin
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
      end else start8 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if ({sum8, co8, busy8, done8} !== 11'b0) begin bad++;
      $display("FAIL reset_w8 got=%h want=0", {sum8, co8, busy8, done8}); end
    total++; if ({sum2, co2, busy2, done2} !== 5'b0) begin bad++;
      $display("FAIL reset_w2 got=%h want=0", {sum2, co2, busy2, done2}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co, st; int nb, nd, da, ol;
    logic [7:0] va[3]; logic [7:0] vb[3]; logic vc[3]; logic [8:0] ve[3];
    va = '{8'h0F, 8'hFF, 8'hFF}; vb = '{8'h01, 8'h01, 8'hFF};
    vc = '{1'b0, 1'b0, 1'b1};    ve = '{9'h010, 9'h100, 9'h1FF};
    for (int k = 0; k < 3; k++) begin
      run8(va[k], vb[k], vc[k], 1'b0, s, co, nb, nd, da, st, ol);
      total++; if ({co, s} !== ve[k]) begin bad++;
        $display("FAIL basic_result[%0d] got=%h want=%h", k, {co, s}, ve[k]); end
      total++; if (nd !== 1 || da !== 8) begin bad++;
        $display("FAIL basic_done[%0d] count=%0d at=%0d want count=1 at=8", k, nd, da); end
      total++; if (nb !== 8 || ol !== 0) begin bad++;
        $display("FAIL basic_busy[%0d] cycles=%0d overlap=%0d want 8/0", k, nb, ol); end
      total++; if (st !== 1'b1) begin bad++;
        $display("FAIL basic_sum_hold[%0d] stable=%0b want=1", k, st); end
      total++; if ({co8, sum8} !== ve[k]) begin bad++;
        $display("FAIL basic_idle_hold[%0d] got=%h want=%h", k, {co8, sum8}, ve[k]); end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] s; logic co, st; int nb, nd, da, ol;
    run8(8'h12, 8'h34, 1'b0, 1'b1, s, co, nb, nd, da, st, ol);
    total++; if ({co, s} !== 9'h046) begin bad++;
      $display("FAIL ignore_result got=%h want=046", {co, s}); end
    total++; if (nd !== 1) begin bad++;
      $display("FAIL ignore_done_count got=%0d want=1", nd); end
    total++; if (nb !== 8) begin bad++;
      $display("FAIL ignore_busy got=%0d want=8", nb); end
    total++; if (st !== 1'b1) begin bad++;
      $display("FAIL ignore_sum_hold stable=%0b want=1", st); end
  endtask

  task automatic test_reset_mid_add();
    logic [7:0] s; logic co, st; int nb, nd, da, ol, ndone;
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    total++; if (busy8 !== 1'b1) begin bad++;
      $display("FAIL rst_mid_pre busy=%0b want=1", busy8); end
    rst_n = 1'b0;
    tick();
    total++; if ({sum8, co8, busy8, done8} !== 11'b0) begin bad++;
      $display("FAIL rst_mid_after got=%h want=0", {sum8, co8, busy8, done8}); end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      tick();
    end
    total++; if (ndone !== 0) begin bad++;
      $display("FAIL rst_mid_no_done got=%0d want=0", ndone); end
    run8(8'h5A, 8'h33, 1'b0, 1'b0, s, co, nb, nd, da, st, ol);
    total++; if ({co, s} !== 9'h08D || nd !== 1 || da !== 8) begin bad++;
      $display("FAIL rst_mid_fresh got=%h done=%0d at=%0d want=08D 1 8", {co, s}, nd, da); end
  endtask

  task automatic test_back_to_back();
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
    tick();
    total++; if (done8 !== 1'b1 || sum8 !== 8'h03) begin bad++;
      $display("FAIL b2b_first done=%0b sum=%h want 1 03", done8, sum8); end
    tick();
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin bad++;
      $display("FAIL b2b_idle busy=%0b done=%0b want 0 0", busy8, done8); end
    tick();
    start8 = 1'b0;
    total++; if (busy8 !== 1'b1) begin bad++;
      $display("FAIL b2b_accept busy=%0b want=1", busy8); end
    for (int i = 0; i < 8; i++) tick();
    total++; if (done8 !== 1'b1 || {co8, sum8} !== 9'h007) begin bad++;
      $display("FAIL b2b_second done=%0b got=%h want 1 007", done8, {co8, sum8}); end
    tick();
  endtask

  task automatic test_exhaustive_w2();
    logic [1:0] s0; logic [2:0] exp; logic stable;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          s0 = sum2; stable = 1'b1;
          a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
          exp = 3'(a + b + c);
          tick();
          start2 = 1'b0;
          for (int i = 0; i < 2; i++) begin
            if (!busy2 || sum2 !== s0) stable = 1'b0;
            tick();
          end
          total++; if ({co2, sum2} !== exp) begin bad++;
            $display("FAIL w2_result a=%0d b=%0d c=%0d got=%0d want=%0d", a, b, c, {co2, sum2}, exp); end
          total++; if (stable !== 1'b1 || done2 !== 1'b1) begin bad++;
            $display("FAIL w2_phase a=%0d b=%0d c=%0d stable=%0b done=%0b want 1 1", a, b, c, stable, done2); end
          tick();
        end
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_add();
    test_back_to_back();
    test_exhaustive_w2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
